// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined segment adder.
// Stage-count derivation and configuration legality helpers.
package adder_pkg;

  // Number of pipeline stages for a given total and segment width.
  function automatic int stage_count(
    input int width,
    input int seg
  );
    return width / seg;
  endfunction

  // Legal configuration: whole segments of at least two bits.
  function automatic bit cfg_ok(
    input int width,
    input int seg
  );
    return (seg >= 2) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/pipelined_segment_adder_segment_adder.sv
// Combinational ripple row of one-bit full adders.
// Exposes the carry into the top bit for overflow detection.
module segment_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_segment_adder.sv
// Skewed add/subtract pipeline, one ripple segment per stage.
// Valid/ready on both sides; the last stage is the output register.
module pipelined_segment_adder
  import adder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = stage_count(WIDTH, SEG_WIDTH);
  localparam int SW     = SEG_WIDTH;

  if (!cfg_ok(WIDTH, SEG_WIDTH)) begin : g_bad_cfg
    $error("WIDTH must be a multiple of SEG_WIDTH, SEG_WIDTH >= 2");
  end

  // Stage registers: operands carried forward, partial sum, carry.
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic              ovf_q;

  // Per-stage inputs (from the previous register) and next values.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] in_v;
  logic [WIDTH-1:0]  in_a [STAGES];
  logic [WIDTH-1:0]  in_b [STAGES];
  logic [WIDTH-1:0]  in_s [STAGES];
  logic              in_c [STAGES];
  logic [WIDTH-1:0]  nx_s [STAGES];
  logic              nx_c [STAGES];
  logic              nx_m [STAGES];

  // Advance chain: a stage moves if empty or its successor moves.
  always_comb begin
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0] && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    seg_s;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      assign in_v[k] = in_valid;
      assign in_a[k] = A;
      assign in_b[k] = Sub ? ~B : B;
      assign in_c[k] = Sub ? 1'b1 : Cin;
      assign in_s[k] = '0;
    end else begin : g_body
      assign in_v[k] = v_q[k-1];
      assign in_a[k] = a_q[k-1];
      assign in_b[k] = b_q[k-1];
      assign in_c[k] = c_q[k-1];
      assign in_s[k] = s_q[k-1];
    end

    segment_adder #(
      .W(SW)
    ) u_seg (
      .a    (in_a[k][k*SW +: SW]),
      .b    (in_b[k][k*SW +: SW]),
      .ci   (in_c[k]),
      .s    (seg_s),
      .co   (nx_c[k]),
      .c_msb(nx_m[k])
    );

    // Splice this segment's result into the running sum.
    always_comb begin
      merged               = in_s[k];
      merged[k*SW +: SW]   = seg_s;
    end

    assign nx_s[k] = merged;
  end

  // Load each stage when it advances; data only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= in_v[k];
          if (in_v[k]) begin
            a_q[k] <= in_a[k];
            b_q[k] <= in_b[k];
            s_q[k] <= nx_s[k];
            c_q[k] <= nx_c[k];
          end
        end
      end
      if (adv[STAGES-1] && in_v[STAGES-1]) begin
        ovf_q <= nx_m[STAGES-1] ^ nx_c[STAGES-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

  logic unused;
  assign unused = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: doc/pipelined_segment_adder.md
Name: pipelined_segment_adder

Overview:
- Parametrised successor to the 4-bit ripple adder.
- A WIDTH-bit add/subtract unit split into SEG_WIDTH-bit ripple segments, one segment per pipeline stage, with carry registered between stages.
- Valid/ready handshakes on input and output, with backpressure.
- Used by the neural-network datapath (neuron accumulation, pixel-sum features) where a full-width ripple carry would limit Fmax.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 4, bits added per pipeline stage.
- STAGES, WIDTH/SEG_WIDTH (derived, not overridable), pipeline depth.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in; ignored when Sub=1.
- Sub  in  1  0: A+B+Cin; 1: A-B (A + ~B + 1).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- Sum  out  WIDTH  result.
- Cout  out  1  carry out of the MSB; for Sub=1 it means no borrow (A>=B unsigned).
- Ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, Sum=0, Cout=0, Ovf=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: every in-flight beat is discarded, with no partial output. A beat offered during a rst cycle is not accepted.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - A, B, Cin and Sub are sampled only on input transfer.
- Stage k (0..STAGES-1):
  - Adds segment k of A and B', where B' = Sub ? ~B : B.
  - Carry-in is the registered carry from stage k-1. For stage 0 it is Sub ? 1 : Cin.
  - Result bits are registered. Upper operand segments and the lower result segments already formed are carried forward in the stage register (skewed pipeline).
- Last stage: registers Sum, Cout and Ovf. Ovf needs the MSB carry-in from inside the last segment.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 beat/cycle.
- Stage advance: stage k advances when its own valid is 0, or when stage k+1 advances. The last stage advances when !out_valid || out_ready.
  - in_ready = !v0 || stage0 advances. It is combinational from out_ready through the chain; no bubble is needed to resume.
- Stall: while out_valid && !out_ready, Sum/Cout/Ovf and every full stage hold.
  - Up to STAGES beats are buffered. in_ready drops only when all stages are full and out_ready=0.
- Simultaneous accept and emit on a full pipe is allowed and loses no beat.
- Arithmetic wraps modulo 2^WIDTH. Sum is unsigned/two's-complement agnostic. Cout and Ovf are both always reported.
- Ordering: strictly FIFO, with no reordering.

Decomposition:
- Shared package adder_pkg:
  - STAGES derivation function.
  - Elaboration check that WIDTH % SEG_WIDTH == 0 and SEG_WIDTH >= 2.
- One natural sub-module, segment_adder: combinational SEG_WIDTH-bit ripple row built from one-bit full adders. Outputs are the segment sum, the carry out, and the carry into the top bit (for Ovf). It is instantiated STAGES times via generate.
- Stage registers and handshake control stay in the top module.

Test Plan:
- Reset then a single beat A=0x1234, B=0x0FF1, Cin=1, Sub=0, out_ready=1 -> out_valid exactly 4 cycles later; Sum=0x2226, Cout=0, Ovf=0; in_ready=1 throughout.
- Carry across every segment boundary: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
- Subtract: A=0x0005, B=0x0007, Sub=1, Cin=1 (ignored) -> Sum=0xFFFE, Cout=0, Ovf=0. Then A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1.
- Backpressure: stream 10 back-to-back beats with out_ready=0 -> exactly 4 accepted, in_ready=0 from the 5th cycle. Raise out_ready -> all 10 results emerge in order, 1/cycle, none dropped or duplicated.
- Random stall: random in_valid/out_ready over 1000 beats, compared against a reference model of {Cout,Sum}=A+B'+c0 -> zero mismatches; order preserved.
- Reset mid-stream with 3 beats in flight -> the cycle after rst: out_valid=0, Sum=0, Cout=0, Ovf=0, no stale beats emitted; a new beat afterwards has latency 4.
